// File: rtl/can_crc_sched_pkg.sv
// Shared definitions for the CAN CRC-15 scheduler: CRC width and polynomial,
// and the scheduler FSM state encoding.
package can_crc_sched_pkg;

   localparam int CRC_W = 15;
   localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/can_crc15_core.sv
// CAN CRC-15 serial LFSR. Clear has priority over enable; one bit per enabled cycle.
module can_crc15_core
   import can_crc_sched_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   logic nxt;

   assign nxt = bit_in ^ crc[CRC_W-1];

   // Shift register: clear at job start, otherwise shift in one bit per accepted bit.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (enable) begin
         crc <= {crc[CRC_W-2:0], 1'b0} ^ (nxt ? CRC_POLY : '0);
      end
   end

endmodule

// File: rtl/can_crc_sched.sv
// Two-requester round-robin scheduler feeding a shared CAN CRC-15 engine.
// Optional stall watchdog enabled by defining CAN_CRC_TIMEOUT_EN.
module can_crc_sched
   import can_crc_sched_pkg::*;
#(
   parameter int LEN_W       = 7,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [1:0]         req,
   input  logic [2*LEN_W-1:0] req_len,
   input  logic [1:0]         bit_valid,
   input  logic [1:0]         bit_data,
   output logic [1:0]         gnt,
   output logic [1:0]         bit_ready,
   output logic               busy,
   output logic               done,
   output logic               done_id,
   output logic [CRC_W-1:0]   crc,
   output logic               crc_zero
`ifdef CAN_CRC_TIMEOUT_EN
   ,
   output logic               timeout
`endif
);

   if (TIMEOUT_CYC < 1) begin : g_timeout_range
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_t             state, state_n;
   logic               owner;
   logic               rr_ptr;
   logic               win;
   logic [LEN_W-1:0]   win_len;
   logic [LEN_W-1:0]   cnt;
   logic               grant;
   logic               accept;
   logic               abort;
   logic [CRC_W-1:0]   core_crc;
   logic [CRC_W-1:0]   crc_q;
   logic               crc_zero_q;
   logic               stall_fire;

   // Round-robin winner: the pointed-to requester if it asks, else the other one.
   assign win     = req[rr_ptr] ? rr_ptr : ~rr_ptr;
   assign win_len = win ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];

`ifdef CAN_CRC_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
   logic [STALL_W-1:0] stall_q;

   // Consecutive-stall counter; restarts on each grant and each accepted bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
      end else if (grant || accept) begin
         stall_q <= '0;
      end else if (state == RUN && !stall_fire) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign timeout = stall_fire;
`endif

   // Next-state decode; a zero-length job (cnt == 0 in RUN) accepts no bits and finishes.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_n    = state;
      grant      = 1'b0;
      accept     = 1'b0;
      abort      = 1'b0;
      stall_fire = 1'b0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               grant   = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (!req[owner]) begin
               abort   = 1'b1;
               state_n = IDLE;
            end else if (cnt == '0) begin
               state_n = DONE;
            end else if (bit_valid[owner]) begin
               accept = 1'b1;
               if (cnt == LEN_W'(1)) state_n = DONE;
            end
`ifdef CAN_CRC_TIMEOUT_EN
            else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
               abort      = 1'b1;
               stall_fire = 1'b1;
               state_n    = IDLE;
            end
`endif
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, grant, owner, bit counter and round-robin pointer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         gnt    <= 2'b00;
         owner  <= 1'b0;
         rr_ptr <= 1'b0;
         cnt    <= '0;
      end else begin
         state <= state_n;
         if (state_n == RUN) begin
            gnt <= (grant ? win : owner) ? 2'b10 : 2'b01;
         end else begin
            gnt <= 2'b00;
         end
         if (grant) begin
            owner <= win;
            cnt   <= win_len;
         end else if (accept) begin
            cnt <= cnt - 1'b1;
         end
         if (abort || state == DONE) begin
            rr_ptr <= ~owner;
         end
      end
   end

   // Result holding registers: capture the engine output when a job completes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         crc_q      <= '0;
         crc_zero_q <= 1'b0;
      end else if (state == DONE) begin
         crc_q      <= core_crc;
         crc_zero_q <= (core_crc == '0);
      end
   end

   can_crc15_core u_core (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (grant),
      .enable  (accept),
      .bit_in  (bit_data[owner]),
      .crc     (core_crc)
   );

   assign busy      = (state == RUN) || (state == DONE);
   assign done      = (state == DONE);
   assign done_id   = done & owner;
   assign bit_ready = {accept & owner, accept & ~owner};
   // During DONE the result is shown straight from the engine; afterwards it is held.
   assign crc       = done ? core_crc : crc_q;
   assign crc_zero  = done ? (core_crc == '0) : crc_zero_q;

endmodule

// File: tb/tb_can_crc_sched.sv
// Directed self-checking bench for can_crc_sched (default build; the stall
// watchdog steps run too when CAN_CRC_TIMEOUT_EN is defined).
module tb_can_crc_sched;

   localparam int LEN_W = 7;

   logic               clock;
   logic               reset_n;
   logic [1:0]         req;
   logic [2*LEN_W-1:0] req_len;
   logic [1:0]         bit_valid;
   logic [1:0]         bit_data;
   logic [1:0]         gnt;
   logic [1:0]         bit_ready;
   logic               busy;
   logic               done;
   logic               done_id;
   logic [14:0]        crc;
   logic               crc_zero;
`ifdef CAN_CRC_TIMEOUT_EN
   logic               timeout;
`endif

   int total = 0;
   int bad   = 0;

   can_crc_sched #(.LEN_W(LEN_W), .TIMEOUT_CYC(255)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .req_len   (req_len),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .gnt       (gnt),
      .bit_ready (bit_ready),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .crc       (crc),
      .crc_zero  (crc_zero)
`ifdef CAN_CRC_TIMEOUT_EN
      ,
      .timeout   (timeout)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One complete job for requester id: grant, len bits (MSB of bits[len-1] first),
   // optional stall cycles before the last bit, DONE checks, then back to IDLE.
   task automatic run_job(input string name, input int id, input int len,
                          input logic [127:0] bits, input int stall,
                          input logic [14:0] exp_crc, input logic exp_zero);
      logic [1:0] oh;
      oh = (id == 0) ? 2'b01 : 2'b10;
      req[id] = 1'b1;
      if (id == 0) req_len[LEN_W-1:0] = LEN_W'(len);
      else         req_len[2*LEN_W-1:LEN_W] = LEN_W'(len);
      tick();
      check({name, "_gnt"}, 32'(gnt), 32'(oh));
      check({name, "_busy"}, 32'(busy), 1);
      if (len == 0) begin
         check({name, "_rdy0"}, 32'(bit_ready), 0);
         tick();
      end
      for (int i = len - 1; i >= 0; i--) begin
         if (i == 0 && stall > 0) begin
            bit_valid = 2'b00;
            for (int s = 0; s < stall; s++) begin
               #1 check({name, "_stall_rdy"}, 32'(bit_ready), 0);
               tick();
            end
         end
         bit_valid[id] = 1'b1;
         bit_data[id]  = bits[i];
         #1 check({name, "_rdy"}, 32'(bit_ready), 32'(oh));
         tick();
      end
      bit_valid = 2'b00;
      req[id]   = 1'b0;
      #1;
      check({name, "_done"}, 32'(done), 1);
      check({name, "_done_id"}, 32'(done_id), 32'(id));
      check({name, "_crc"}, 32'(crc), 32'(exp_crc));
      check({name, "_crc_zero"}, 32'(crc_zero), 32'(exp_zero));
      check({name, "_gnt_off"}, 32'(gnt), 0);
      tick();
      check({name, "_idle_done"}, 32'(done), 0);
      check({name, "_idle_busy"}, 32'(busy), 0);
      check({name, "_crc_held"}, 32'(crc), 32'(exp_crc));
   endtask

   initial begin
      reset_n   = 1'b1;
      req       = 2'b00;
      req_len   = '0;
      bit_valid = 2'b00;
      bit_data  = 2'b00;

      // Reset values, forced asynchronously before any clock edge.
      #2 reset_n = 1'b0;
      #1;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rdy", 32'(bit_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_done_id", 32'(done_id), 0);
      check("rst_crc", 32'(crc), 0);
      check("rst_crc_zero", 32'(crc_zero), 0);
`ifdef CAN_CRC_TIMEOUT_EN
      check("rst_timeout", 32'(timeout), 0);
`endif
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Single bit '1' -> 0x4599.
      run_job("single", 0, 1, 128'h1, 0, 15'h4599, 1'b0);
      // Zero-length job -> crc 0, crc_zero 1.
      run_job("zero_len", 1, 0, 128'h0, 0, 15'h0000, 1'b1);
      // Bit 1 then 0x4599 MSB first, with a 3-cycle stall -> residue 0.
      run_job("selfchk", 1, 16, 128'hC599, 3, 15'h0000, 1'b1);
      // Bits "10" -> 0x4EAB.
      run_job("two_bits", 0, 2, 128'h2, 0, 15'h4EAB, 1'b0);

      // Reset asserted mid-job: outputs drop at once, job discarded.
      req       = 2'b01;
      req_len   = {LEN_W'(0), LEN_W'(8)};
      tick();
      check("mid_gnt", 32'(gnt), 1);
      bit_valid = 2'b01;
      bit_data  = 2'b01;
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(gnt), 0);
      check("mid_rst_rdy", 32'(bit_ready), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_crc", 32'(crc), 0);
      check("mid_rst_crc_zero", 32'(crc_zero), 0);
      tick();
      check("mid_rst_done2", 32'(done), 0);
      req       = 2'b00;
      bit_valid = 2'b00;
      reset_n   = 1'b1;
      tick();

      // Contention after reset: grants 0, 1, 0 with DONE and one IDLE between.
      req       = 2'b11;
      req_len   = {LEN_W'(1), LEN_W'(1)};
      bit_valid = 2'b11;
      bit_data  = 2'b11;
      tick();
      check("cont_gnt0", 32'(gnt), 2'b01);
      check("cont_rdy0", 32'(bit_ready), 2'b01);
      tick();
      check("cont_done0", 32'(done), 1);
      check("cont_done_id0", 32'(done_id), 0);
      check("cont_crc0", 32'(crc), 15'h4599);
      check("cont_gnt_done0", 32'(gnt), 0);
      tick();
      check("cont_idle_gnt", 32'(gnt), 0);
      check("cont_idle_busy", 32'(busy), 0);
      tick();
      check("cont_gnt1", 32'(gnt), 2'b10);
      check("cont_rdy1", 32'(bit_ready), 2'b10);
      tick();
      check("cont_done1", 32'(done), 1);
      check("cont_done_id1", 32'(done_id), 1);
      tick();
      check("cont_idle2_busy", 32'(busy), 0);
      tick();
      check("cont_gnt2", 32'(gnt), 2'b01);
      req       = 2'b00;
      bit_valid = 2'b00;
      tick();

      // Abort: owner 0 drops req after 3 bits; requester 1 is granted next.
      reset_n = 1'b0;
      tick();
      reset_n   = 1'b1;
      req       = 2'b11;
      req_len   = {LEN_W'(2), LEN_W'(8)};
      tick();
      check("abort_gnt0", 32'(gnt), 2'b01);
      bit_valid = 2'b11;
      bit_data  = 2'b01;
      for (int i = 0; i < 3; i++) begin
         #1 check("abort_rdy", 32'(bit_ready), 2'b01);
         tick();
      end
      bit_valid = 2'b00;
      req       = 2'b10;
      #1 check("abort_no_done", 32'(done), 0);
      tick();
      check("abort_idle_busy", 32'(busy), 0);
      check("abort_idle_done", 32'(done), 0);
      check("abort_idle_gnt", 32'(gnt), 0);
      tick();
      check("abort_gnt1", 32'(gnt), 2'b10);
      bit_valid = 2'b10;
      bit_data  = 2'b10;
      tick();
      bit_data  = 2'b00;
      tick();
      bit_valid = 2'b00;
      req       = 2'b00;
      #1;
      check("abort_done1", 32'(done), 1);
      check("abort_done_id1", 32'(done_id), 1);
      check("abort_crc1", 32'(crc), 15'h4EAB);
      tick();

`ifdef CAN_CRC_TIMEOUT_EN
      // Stall watchdog: 255 consecutive stall cycles abort with a timeout pulse.
      req     = 2'b01;
      req_len = {LEN_W'(0), LEN_W'(4)};
      tick();
      check("to_gnt", 32'(gnt), 2'b01);
      for (int i = 1; i < 255; i++) begin
         if (i == 1 || i == 254) check("to_early", 32'(timeout), 0);
         tick();
      end
      check("to_pulse", 32'(timeout), 1);
      check("to_no_done", 32'(done), 0);
      req = 2'b00;
      tick();
      check("to_pulse_end", 32'(timeout), 0);
      check("to_idle_busy", 32'(busy), 0);
      check("to_idle_done", 32'(done), 0);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/can_crc_sched.md
CAN_CRC_SCHED -- requirements
Module: can_crc_sched

Interface
REQ-001 Parameter: LEN_W, 7, width of each requester's bit-count field (max 127 bits per job).
REQ-002 Parameter: TIMEOUT_CYC, 255, stall limit in cycles while owner withholds bit_valid (used only with CAN_CRC_TIMEOUT_EN).
REQ-003 Ports, in this order:
- clock, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- req, in, 2: per-requester job request (0 = TX path, 1 = RX path), level.
- req_len, in, 2*LEN_W: bit count per requester; requester i uses bits [i*LEN_W +: LEN_W].
- bit_valid, in, 2: per-requester serial bit valid.
- bit_data, in, 2: per-requester serial bit, MSB of frame first.
- gnt, out, 2: one-hot grant, registered.
- bit_ready, out, 2: bit accepted this cycle.
- busy, out, 1: job in progress.
- done, out, 1: one-cycle completion pulse.
- done_id, out, 1: requester index of the completed job.
- crc, out, 15: CRC-15 result.
- crc_zero, out, 1: crc == 0 at done; used for RX self-check.
- timeout, out, 1: one-cycle abort pulse (present only with CAN_CRC_TIMEOUT_EN).

Function
REQ-004 FSM SHALL have states IDLE, RUN and DONE.
REQ-005 IDLE SHALL do the following when any req is high:
- Grant by round-robin.
- Capture req_len of the winner into the bit counter.
- Clear the CRC register to 0.
- Go to RUN, with gnt asserted in the next cycle.
REQ-006 Round-robin SHALL favour requester 0 after reset; the pointer SHALL move to the non-completing requester after each done or abort.
REQ-007 In RUN, bit_ready[owner] SHALL equal bit_valid[owner]; bit_ready for the non-owner SHALL be 0.
REQ-008 Each accepted bit SHALL update the CRC register and decrement the counter.
REQ-009 CRC update SHALL be: nxt = bit ^ crc[14]; crc = {crc[13:0],1'b0} ^ (nxt ? 15'h4599 : 0).
REQ-010 A cycle without bit_valid[owner] SHALL leave the CRC register and counter unchanged (stall).
REQ-011 Acceptance of the bit that takes the counter from 1 to 0 SHALL move the FSM to DONE in the next cycle.
REQ-012 DONE SHALL last one cycle and SHALL:
- Pulse done and drive done_id.
- Drive crc_zero.
- Deassert gnt.
- Return to IDLE.
REQ-013 A grant with req_len == 0 SHALL go directly from grant to DONE with crc = 0 and crc_zero = 1.
REQ-014 If the owner drops req while in RUN, the job SHALL be aborted: return to IDLE with no done pulse and the pointer advanced.
REQ-015 crc and crc_zero SHALL hold their values from the last DONE until the next DONE.
REQ-016 busy SHALL be high in RUN and DONE.
REQ-017 A new grant SHALL occur no earlier than the cycle after DONE, giving at least one IDLE cycle between jobs.

Reset
REQ-018 While reset_n is low, the block SHALL immediately force:
- state = IDLE;
- gnt, bit_ready, busy, done, done_id, timeout = 0;
- crc = 0 and crc_zero = 0;
- counter = 0;
- round-robin pointer to requester 0.
REQ-019 Reset asserted mid-job SHALL discard the job with no done pulse.

Configuration
REQ-020 With CAN_CRC_TIMEOUT_EN defined, a stall counter SHALL run as follows:
- It clears on every accepted bit and on entry to RUN.
- When it reaches TIMEOUT_CYC consecutive stall cycles in RUN, it aborts the job as in REQ-014 and pulses timeout.
REQ-021 Without CAN_CRC_TIMEOUT_EN, the timeout port and the stall counter SHALL be absent, and a stall SHALL last indefinitely.

Structure
REQ-022 A shared package SHALL hold:
- the CRC-15 polynomial constant 15'h4599;
- the CRC width constant 15;
- the state enum encodings IDLE/RUN/DONE.
REQ-023 The LFSR SHALL be a sub-module, can_crc15_core, with clear, enable and bit inputs and a 15-bit output.
REQ-024 Arbitration, counter and FSM SHALL reside in can_crc_sched.

Verification
REQ-025 Single bit: req[0], len 1, bit 1 -> done after 1 accepted bit, crc = 0x4599, done_id = 0, crc_zero = 0.
REQ-026 Two bits: bits "10", len 2 -> crc = 0x4EAB.
REQ-027 Self-check: len 16, bit 1 then 0x4599 MSB first -> crc = 0x0000, crc_zero = 1.
REQ-028 Contention: req = 2'b11 held after reset -> grants alternate 0, 1, 0, each separated by DONE and one IDLE cycle.
REQ-029 Abort and zero length: owner drops req after 3 bits -> no done, other requester granted next. Separately, len 0 -> done with crc = 0.
REQ-030 Reset and timeout:
- reset_n low mid-job -> all outputs at reset values within the same cycle, no done.
- With CAN_CRC_TIMEOUT_EN: 255 stall cycles -> timeout pulse, no done.
